// File: rtl/block_ram_param.sv
// Simple dual-port block RAM with lane-granular writes/reads, selectable
// read-during-write policy and an optional extra output register stage.
module block_ram_param #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned RDW_MODE   = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            cfg_wr_mode,
   input  logic [1:0]            cfg_rd_mode,
   input  logic                  cfg_out_reg,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH+1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH+1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam int unsigned Q     = DATA_WIDTH / 4;
   localparam int unsigned H     = DATA_WIDTH / 2;
   localparam logic [DATA_WIDTH-1:0] QMASK = DATA_WIDTH'({Q{1'b1}});
   localparam logic [DATA_WIDTH-1:0] HMASK = DATA_WIDTH'({H{1'b1}});

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [ADDR_WIDTH-1:0] wr_word;
   logic [ADDR_WIDTH-1:0] rd_word;
   logic                  wr_hit;
   logic [DATA_WIDTH-1:0] wr_mask;
   logic [DATA_WIDTH-1:0] wr_exp;
   logic [DATA_WIDTH-1:0] rd_raw;
   logic [DATA_WIDTH-1:0] rd_fmt;

   logic                  p1_valid_q, p1_valid_d;
   logic [DATA_WIDTH-1:0] p1_data_q,  p1_data_d;
   logic                  rd_valid_q, rd_valid_d;
   logic [DATA_WIDTH-1:0] rd_data_q,  rd_data_d;

   // Bit mask of the lanes touched by an access of the given width
   function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [1:0] mode,
                                                       input logic [1:0] lane);
      case (mode)
         2'd1:    lane_mask = lane[1] ? (HMASK << H) : HMASK;
         2'd2:    lane_mask = QMASK << (Q * 32'(lane));
         default: lane_mask = '1;
      endcase
   endfunction

   // Selected lane(s) shifted down to the LSBs, upper bits zero
   function automatic logic [DATA_WIDTH-1:0] lane_extract(input logic [DATA_WIDTH-1:0] word,
                                                          input logic [1:0] mode,
                                                          input logic [1:0] lane);
      case (mode)
         2'd1:    lane_extract = lane[1] ? (word >> H) : (word & HMASK);
         2'd2:    lane_extract = (word >> (Q * 32'(lane))) & QMASK;
         default: lane_extract = word;
      endcase
   endfunction

   assign wr_word = wr_addr[ADDR_WIDTH+1:2];
   assign rd_word = rd_addr[ADDR_WIDTH+1:2];

   // Write-side lane decode; narrow data is replicated so the mask picks it up
   always_comb begin
      wr_hit  = wr_en & ~rst;
      wr_mask = lane_mask(cfg_wr_mode, wr_addr[1:0]);
      case (cfg_wr_mode)
         2'd1:    wr_exp = {2{wr_data[H-1:0]}};
         2'd2:    wr_exp = {4{wr_data[Q-1:0]}};
         default: wr_exp = wr_data;
      endcase
   end

   // Read-side word fetch with optional new-data bypass, then lane formatting
   always_comb begin
      rd_raw = mem_q[rd_word];
      if (RDW_MODE == 1 && wr_hit && (wr_word == rd_word)) begin
         rd_raw = (rd_raw & ~wr_mask) | (wr_exp & wr_mask);
      end
      rd_fmt = lane_extract(rd_raw, cfg_rd_mode, rd_addr[1:0]);
   end

   // Pipeline next-state: read result is formatted at request time
   always_comb begin
      p1_valid_d = rd_en;
      p1_data_d  = rd_en ? rd_fmt : p1_data_q;
      rd_valid_d = rd_en;
      rd_data_d  = rd_en ? rd_fmt : rd_data_q;
      if (cfg_out_reg) begin
         rd_valid_d = p1_valid_q;
         rd_data_d  = p1_valid_q ? p1_data_q : rd_data_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p1_valid_q <= 1'b0;
         p1_data_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         p1_valid_q <= p1_valid_d;
         p1_data_q  <= p1_data_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   // Memory array is never reset
   always_ff @(posedge clk) begin
      if (wr_hit) begin
         mem_q[wr_word] <= (mem_q[wr_word] & ~wr_mask) | (wr_exp & wr_mask);
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_block_ram_param.sv
// Directed bench for block_ram_param: one instance per read-during-write policy.
module tb_block_ram_param;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    cfg_wr_mode, cfg_rd_mode;
   logic          cfg_out_reg;
   logic          wr_en, rd_en;
   logic [AW+1:0] wr_addr, rd_addr;
   logic [DW-1:0] wr_data;
   logic [DW-1:0] rd_data0, rd_data1;
   logic          rd_valid0, rd_valid1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   block_ram_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(0)) u_old (
      .clk(clk), .rst(rst), .cfg_wr_mode(cfg_wr_mode), .cfg_rd_mode(cfg_rd_mode),
      .cfg_out_reg(cfg_out_reg), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0));

   block_ram_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(1)) u_new (
      .clk(clk), .rst(rst), .cfg_wr_mode(cfg_wr_mode), .cfg_rd_mode(cfg_rd_mode),
      .cfg_out_reg(cfg_out_reg), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Checks both instances for a response with identical expected values
   task automatic chk_out(input string tag, input logic v, input logic [31:0] d);
      chk({tag, "_v0"}, 32'(rd_valid0), 32'(v));
      chk({tag, "_d0"}, rd_data0, d);
      chk({tag, "_v1"}, 32'(rd_valid1), 32'(v));
      chk({tag, "_d1"}, rd_data1, d);
   endtask

   task automatic wr(input logic [1:0] mode, input logic [AW+1:0] a, input logic [31:0] d);
      cfg_wr_mode = mode; wr_addr = a; wr_data = d; wr_en = 1'b1;
      step();
      wr_en = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cfg_wr_mode = 2'd0; cfg_rd_mode = 2'd0; cfg_out_reg = 1'b0;
      wr_en = 1'b0; rd_en = 1'b0; wr_addr = '0; rd_addr = '0; wr_data = '0;
      step(); step();
      chk_out("reset", 1'b0, 32'h0);
      rst = 1'b0;

      // Full-width round trip, 1-cycle latency
      wr(2'd0, 10'd20, 32'hDEADBEEF);
      rd_en = 1'b1; rd_addr = 10'd20; cfg_rd_mode = 2'd0;
      step();
      chk_out("full_rt", 1'b1, 32'hDEADBEEF);
      rd_en = 1'b0;
      step();
      chk_out("idle_hold", 1'b0, 32'hDEADBEEF);

      // Quarter writes to word 3 with junk in the upper bits of wr_data
      wr(2'd2, 10'd12, 32'hFFFFFF11);
      wr(2'd2, 10'd13, 32'hABCDEF22);
      wr(2'd2, 10'd14, 32'h12345633);
      wr(2'd2, 10'd15, 32'h00000044);
      rd_en = 1'b1; rd_addr = 10'd12; cfg_rd_mode = 2'd0;
      step();
      chk_out("quarter_wr", 1'b1, 32'h44332211);
      rd_en = 1'b0;

      // Half read, upper half, 2-cycle latency; mode changes while in flight
      cfg_out_reg = 1'b1;
      step();
      rd_en = 1'b1; rd_addr = 10'd14; cfg_rd_mode = 2'd1;
      step();
      chk_out("half_lat1", 1'b0, 32'h44332211);
      rd_en = 1'b0; cfg_rd_mode = 2'd0;
      step();
      chk_out("half_rd", 1'b1, 32'h00004433);
      step();
      chk_out("half_after", 1'b0, 32'h00004433);
      cfg_out_reg = 1'b0;

      // Half write lower half, then quarter read of lane 1
      wr(2'd1, 10'd13, 32'hFFFFBEEF);
      rd_en = 1'b1; rd_addr = 10'd13; cfg_rd_mode = 2'd2;
      step();
      chk_out("quarter_rd", 1'b1, 32'h000000BE);
      rd_addr = 10'd12; cfg_rd_mode = 2'd0;
      step();
      chk_out("half_wr", 1'b1, 32'h4433BEEF);
      rd_en = 1'b0;

      // Read-during-write to the same word
      wr(2'd0, 10'd28, 32'hAAAAAAAA);
      wr_en = 1'b1; cfg_wr_mode = 2'd2; wr_addr = 10'd28; wr_data = 32'h00000055;
      rd_en = 1'b1; rd_addr = 10'd28; cfg_rd_mode = 2'd0;
      step();
      wr_en = 1'b0;
      chk("rdw_old_d", rd_data0, 32'hAAAAAAAA);
      chk("rdw_new_d", rd_data1, 32'hAAAAAA55);
      chk("rdw_old_v", 32'(rd_valid0), 32'd1);
      chk("rdw_new_v", 32'(rd_valid1), 32'd1);
      step();
      chk_out("rdw_mem", 1'b1, 32'hAAAAAA55);
      rd_en = 1'b0;

      // Read and write to different words on the same edge
      wr_en = 1'b1; cfg_wr_mode = 2'd0; wr_addr = 10'd32; wr_data = 32'h13572468;
      rd_en = 1'b1; rd_addr = 10'd20;
      step();
      wr_en = 1'b0;
      chk_out("diff_word", 1'b1, 32'hDEADBEEF);
      rd_addr = 10'd32;
      step();
      chk_out("diff_word_wr", 1'b1, 32'h13572468);
      rd_en = 1'b0;

      // Back-to-back reads of words 0..3
      for (int i = 0; i < 4; i++) wr(2'd0, 10'(i * 4), 32'h100 + 32'(i));
      rd_en = 1'b1; cfg_rd_mode = 2'd0;
      for (int i = 0; i < 4; i++) begin
         rd_addr = 10'(i * 4);
         step();
         chk_out($sformatf("b2b%0d", i), 1'b1, 32'h100 + 32'(i));
      end
      rd_en = 1'b0;
      step();
      chk_out("b2b_end", 1'b0, 32'h103);

      // Reset with a read in flight and a write attempted during reset
      cfg_out_reg = 1'b1;
      step();
      rd_en = 1'b1; rd_addr = 10'd0;
      step();
      rst = 1'b1; rd_addr = 10'd4;
      wr_en = 1'b1; cfg_wr_mode = 2'd0; wr_addr = 10'd0; wr_data = 32'h00000BAD;
      step();
      chk_out("rst_in", 1'b0, 32'h0);
      rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
      step();
      chk_out("rst_post1", 1'b0, 32'h0);
      step();
      chk_out("rst_post2", 1'b0, 32'h0);

      // Memory survives reset; first read after reset is normal
      rd_en = 1'b1; rd_addr = 10'd0;
      step();
      chk_out("post_lat1", 1'b0, 32'h0);
      rd_en = 1'b0;
      step();
      chk_out("post_rd", 1'b1, 32'h100);
      step();
      chk_out("post_idle", 1'b0, 32'h100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
